// File: rtl/bram_sdp_clr_if.sv
// rtl/bram_sdp_clr_if.sv - write/read/clear port bundle of the simple-dual-port clearable RAM
interface bram_sdp_clr_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int BIT_WIDTH  = 32
);
    localparam int NB = BIT_WIDTH / 8;

    logic                  CLR;
    logic                  BUSY;
    logic                  ENA;
    logic [NB-1:0]         WEA;
    logic [ADDR_WIDTH-1:0] AA;
    logic [BIT_WIDTH-1:0]  DiA;
    logic                  ENB;
    logic [ADDR_WIDTH-1:0] AB;
    logic [BIT_WIDTH-1:0]  DoB;
    logic                  DoB_VLD;

    modport master (
        output CLR, ENA, WEA, AA, DiA, ENB, AB,
        input  BUSY, DoB, DoB_VLD
    );

    modport slave (
        input  CLR, ENA, WEA, AA, DiA, ENB, AB,
        output BUSY, DoB, DoB_VLD
    );
endinterface

// File: rtl/bram_sdp_clr.sv
// rtl/bram_sdp_clr.sv - simple-dual-port byte-writable RAM with clear engine and 1/2-cycle read
module bram_sdp_clr #(
    parameter int ADDR_WIDTH   = 12,
    parameter int SIZE         = 11,
    parameter int BIT_WIDTH    = 32,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 1
) (
    input  logic           CLK,
    input  logic           RST,
    bram_sdp_clr_if.slave  bus
);
    localparam int NB    = BIT_WIDTH / 8;
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [ADDR_WIDTH:0] SIZE_W   = (ADDR_WIDTH + 1)'(SIZE);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(SIZE - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     clr_addr_q;
    logic [BIT_WIDTH-1:0] mem [DEPTH];

    logic                 busy;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 rd_in_range;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic [BIT_WIDTH-1:0] rd_word_d;
    logic [BIT_WIDTH-1:0] dob_q;
    logic                 dob_vld_q;

    // Out-of-range addresses are rejected before truncation, so no aliasing onto real words.
    assign busy        = (state_q == ST_CLEAR);
    assign wr_acc      = bus.ENA & ~busy & ({1'b0, bus.AA} < SIZE_W);
    assign rd_acc      = bus.ENB & ~busy;
    assign rd_in_range = ({1'b0, bus.AB} < SIZE_W);
    assign wr_idx      = bus.AA[IDX_W-1:0];
    assign rd_idx      = bus.AB[IDX_W-1:0];

    // Read word: zero when out of range, otherwise stored word, merged with same-cycle write bytes in write-first mode.
    always_comb begin
        rd_word_d = '0;
        if (rd_in_range) begin
            rd_word_d = mem[rd_idx];
            if ((WRITE_FIRST != 0) && wr_acc && (bus.AA == bus.AB)) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.WEA[i]) begin
                        rd_word_d[8*i +: 8] = bus.DiA[8*i +: 8];
                    end
                end
            end
        end
    end

    // Clear engine: one word per cycle from address 0; CLR while clearing is ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    clr_addr_q <= '0;
                    if (bus.CLR) begin
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr_q == LAST_IDX) begin
                        state_q    <= ST_IDLE;
                        clr_addr_q <= '0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_CLEAR;
                    clr_addr_q <= '0;
                end
            endcase
        end
    end

    // Array write: the clear engine owns the array while busy, otherwise port A with per-byte enables.
    always_ff @(posedge CLK) begin
        if (busy) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.WEA[i]) begin
                    mem[wr_idx][8*i +: 8] <= bus.DiA[8*i +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                 s1_vld_q;
            logic [BIT_WIDTH-1:0] s1_data_q;

            // Two-stage read pipeline; DoB only updates when a result arrives.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
                    dob_vld_q <= 1'b0;
                    dob_q     <= '0;
                end else begin
                    s1_vld_q  <= rd_acc;
                    dob_vld_q <= s1_vld_q;
                    if (rd_acc) begin
                        s1_data_q <= rd_word_d;
                    end
                    if (s1_vld_q) begin
                        dob_q <= s1_data_q;
                    end
                end
            end
        end else begin : g_lat1
            // Single registered read; DoB holds the last result between requests.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    dob_vld_q <= 1'b0;
                    dob_q     <= '0;
                end else begin
                    dob_vld_q <= rd_acc;
                    if (rd_acc) begin
                        dob_q <= rd_word_d;
                    end
                end
            end
        end
    endgenerate

    assign bus.BUSY    = busy;
    assign bus.DoB     = dob_q;
    assign bus.DoB_VLD = dob_vld_q;
endmodule
